stack_op_sequencer: RTL and testbench
=====================================

// Module: stack_op_sequencer
// PURPOSE
//  Multi-cycle controller for CALL/RET/INT/RTI stack traffic. It splits the 32-bit
//  PC (and the CCR flags for INT/RTI) into 16-bit words and sequences them through
//  the shared 16-bit data-memory port. It owns the stack pointer and stalls fetch/decode
//  while busy, then issues a single PC-load pulse. Sits between decode and the memory stage.
// PARAMETERS
//  ADDR_W   32            width of SP and mem_addr (word addressed)
//  DW       16            memory word width; PC is 2*DW
//  FLAG_W   4             CCR width, zero-extended to DW on push
//  SP_INIT  32'h0000_0FFE SP value after reset
// PORTS
//  clk        in   1        clock; all state updates on posedge
//  reset      in   1        asynchronous, active-low reset
//  op_valid   in   1        request strobe from decode; sampled only when op_ready=1
//  op_code    in   2        00 CALL, 01 RET, 10 INT, 11 RTI
//  ret_pc     in   2*DW     return address to push (CALL/INT)
//  target_pc  in   2*DW     jump target (CALL) / interrupt vector (INT)
//  flags_in   in   FLAG_W   current CCR (pushed by INT)
//  op_ready   out  1        1 in IDLE only
//  stall      out  1        freeze fetch/decode; 1 from accept edge through DONE cycle
//  mem_req    out  1        memory access request, held until mem_ack
//  mem_we     out  1        1 = write (push), 0 = read (pop); valid with mem_req
//  mem_addr   out  ADDR_W   word address; valid with mem_req
//  mem_wdata  out  DW       push data; valid with mem_req & mem_we
//  mem_rdata  in   DW       pop data; valid in the mem_ack cycle
//  mem_ack    in   1        access complete this cycle; ignored when mem_req=0
//  pc_load    out  1        one-cycle pulse in DONE
//  pc_next    out  2*DW     new PC; valid with pc_load
//  flags_load out  1        one-cycle pulse in DONE for RTI only
//  flags_out  out  FLAG_W   restored CCR; valid with flags_load
//  sp_out     out  ADDR_W   current SP (for debug and the SP-relative datapath)
// BEHAVIOUR
//  Reset (async, reset=0): state=IDLE, SP=SP_INIT, every output 0 except op_ready=1 and sp_out=SP_INIT.
//  Stack grows downward. Push: mem[SP]<=w, then SP<=SP-1. Pop: SP<=SP+1, then w<=mem[SP].
//  SP arithmetic wraps modulo 2^ADDR_W; no overflow or underflow flag.
//  States: IDLE, PUSH_F, PUSH_LO, PUSH_HI, POP_HI, POP_LO, POP_F, DONE.
//  IDLE & op_valid -> latch op_code, ret_pc, target_pc, flags_in; then go to:
//   CALL: PUSH_LO; INT: PUSH_F; RET/RTI: POP_HI.
//  Push order: INT: PUSH_F -> PUSH_LO -> PUSH_HI. CALL: PUSH_LO -> PUSH_HI.
//  Pop order: RET: POP_HI -> POP_LO. RTI: POP_HI -> POP_LO -> POP_F. Pop order is the exact inverse of push.
//  Each access state drives mem_req=1 with its address and data. It advances only on a posedge with mem_ack=1.
//   SP updates on that same edge. mem_req, mem_addr and mem_wdata hold stable while waiting.
//  Last access -> DONE (mem_req=0). DONE lasts exactly 1 cycle, then IDLE.
//   In DONE: pc_load=1. pc_next = latched target_pc (CALL/INT) or {hi,lo} popped (RET/RTI).
//  Latency with zero-wait ack: CALL/RET 4 cycles accept-to-IDLE, INT/RTI 5.
//   Each wait cycle adds 1.
//  op_valid is ignored outside IDLE; no queueing. Requests in the DONE cycle are dropped, and decode must retry.
//  Reset mid-operation aborts immediately. A partially pushed frame is abandoned and SP returns to SP_INIT.
//  Pop address uses SP+1 combinationally. POP_F loads flags_out from mem_rdata[FLAG_W-1:0].
// STRUCTURE
//  Package stack_seq_pkg holds: op_code localparams (OP_CALL..OP_RTI), state encoding, SP_INIT default.
//  One sub-module, stack_pointer_reg: async-reset SP register with inc/dec enables; exports sp and sp_plus1.
//  FSM, latches and output decode stay in the top module.
// TESTING
//  CALL, SP=0x0FFE, ret_pc=0x0001_2345, target=0x0000_0100, ack every cycle
//   -> mem[0x0FFE]=0x2345, mem[0x0FFD]=0x0001; SP=0x0FFC.
//   -> pc_load with pc_next=0x0000_0100; stall for 4 cycles.
//  RET immediately after that CALL
//   -> reads 0x0FFD then 0x0FFE; pc_next=0x0001_2345; SP=0x0FFE.
//  INT with flags_in=4'b1010, ret_pc=0x0000_00AA
//   -> mem[0x0FFE]=0x000A, mem[0x0FFD]=0x00AA, mem[0x0FFC]=0x0000; SP=0x0FFB.
//   -> followed by RTI: flags_load with flags_out=4'b1010, pc_next=0x0000_00AA, SP=0x0FFE.
//  CALL with mem_ack delayed 3 cycles per access
//   -> mem_req, mem_addr and mem_wdata stable while waiting; stall lasts 10 cycles; SP changes only on ack edges.
//  op_valid pulsed every cycle during a CALL
//   -> exactly one op accepted; op_ready=0 until back in IDLE.
//  reset=0 asserted while in PUSH_HI
//   -> same cycle: mem_req=0 and stall=0; SP=SP_INIT; op_ready=1.
//  SP_INIT=0 with a CALL
//   -> addresses 0x0000 then 0xFFFF_FFFF; SP wraps to 0xFFFF_FFFE.

Source files
------------

// File: rtl/stack_op_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : stack_seq_pkg                                                    |
// | Shared op codes, FSM state encoding and reset SP for the stack sequencer.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package stack_seq_pkg;

    typedef logic [1:0] op_code_t;

    localparam op_code_t OP_CALL = 2'b00;
    localparam op_code_t OP_RET  = 2'b01;
    localparam op_code_t OP_INT  = 2'b10;
    localparam op_code_t OP_RTI  = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PUSH_F  = 3'd1,
        PUSH_LO = 3'd2,
        PUSH_HI = 3'd3,
        POP_HI  = 3'd4,
        POP_LO  = 3'd5,
        POP_F   = 3'd6,
        DONE    = 3'd7
    } state_t;

    localparam logic [31:0] SP_INIT_DEFAULT = 32'h0000_0FFE;

endpackage
`default_nettype wire

// File: rtl/stack_op_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : stack_op_sequencer_if                                          |
// | Decode request, data-memory port and PC/CCR load bundle of the sequencer.  |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
interface stack_op_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DW     = 16,
    parameter int FLAG_W = 4
);
    import stack_seq_pkg::*;

    logic                op_valid;
    op_code_t            op_code;
    logic [2*DW-1:0]     ret_pc;
    logic [2*DW-1:0]     target_pc;
    logic [FLAG_W-1:0]   flags_in;
    logic                op_ready;
    logic                stall;
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DW-1:0]       mem_wdata;
    logic [DW-1:0]       mem_rdata;
    logic                mem_ack;
    logic                pc_load;
    logic [2*DW-1:0]     pc_next;
    logic                flags_load;
    logic [FLAG_W-1:0]   flags_out;
    logic [ADDR_W-1:0]   sp_out;

    modport master (
        output op_valid, op_code, ret_pc, target_pc, flags_in, mem_rdata, mem_ack,
        input  op_ready, stall, mem_req, mem_we, mem_addr, mem_wdata,
               pc_load, pc_next, flags_load, flags_out, sp_out
    );

    modport slave (
        input  op_valid, op_code, ret_pc, target_pc, flags_in, mem_rdata, mem_ack,
        output op_ready, stall, mem_req, mem_we, mem_addr, mem_wdata,
               pc_load, pc_next, flags_load, flags_out, sp_out
    );

endinterface
`default_nettype wire

// File: rtl/stack_op_sequencer_sp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : stack_pointer_reg                                                |
// | Stack pointer with increment/decrement enables, wraps modulo 2^ADDR_W.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module stack_pointer_reg
    import stack_seq_pkg::*;
#(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] SP_INIT = ADDR_W'(SP_INIT_DEFAULT)
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              inc,
    input  wire logic              dec,
    output logic [ADDR_W-1:0]      sp,
    output logic [ADDR_W-1:0]      sp_plus1
);

    logic [ADDR_W-1:0] r_sp;
    logic [ADDR_W-1:0] w_sp_plus1;

    assign w_sp_plus1 = r_sp + ADDR_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sp <= SP_INIT;
        end else if (inc) begin
            r_sp <= w_sp_plus1;
        end else if (dec) begin
            r_sp <= r_sp - ADDR_W'(1);
        end
    end

    assign sp       = r_sp;
    assign sp_plus1 = w_sp_plus1;

endmodule
`default_nettype wire

// File: rtl/stack_op_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : stack_op_sequencer                                               |
// | Sequences CALL/RET/INT/RTI PC and CCR words through a 16-bit memory port.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module stack_op_sequencer
    import stack_seq_pkg::*;
#(
    parameter int                ADDR_W  = 32,
    parameter int                DW      = 16,
    parameter int                FLAG_W  = 4,
    parameter logic [ADDR_W-1:0] SP_INIT = ADDR_W'(SP_INIT_DEFAULT)
) (
    input  wire logic            clk,
    input  wire logic            reset,
    stack_op_sequencer_if.slave  bus
);

    state_t             r_state;
    state_t             w_next_state;
    op_code_t           r_op;
    logic [2*DW-1:0]    r_ret_pc;
    logic [2*DW-1:0]    r_target_pc;
    logic [FLAG_W-1:0]  r_flags;
    logic [DW-1:0]      r_pop_hi;
    logic [DW-1:0]      r_pop_lo;
    logic [FLAG_W-1:0]  r_pop_flags;

    logic               w_accept;
    logic               w_mem_req;
    logic               w_mem_we;
    logic [ADDR_W-1:0]  w_mem_addr;
    logic [DW-1:0]      w_mem_wdata;
    logic               w_sp_inc;
    logic               w_sp_dec;
    logic [ADDR_W-1:0]  w_sp;
    logic [ADDR_W-1:0]  w_sp_plus1;
    logic               w_done;
    logic               w_is_pop_op;

    stack_pointer_reg #(
        .ADDR_W  (ADDR_W),
        .SP_INIT (SP_INIT)
    ) u_sp (
        .clk      (clk),
        .reset    (reset),
        .inc      (w_sp_inc),
        .dec      (w_sp_dec),
        .sp       (w_sp),
        .sp_plus1 (w_sp_plus1)
    );

    assign w_accept = (r_state == IDLE) && bus.op_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op        <= OP_CALL;
            r_ret_pc    <= '0;
            r_target_pc <= '0;
            r_flags     <= '0;
            r_pop_hi    <= '0;
            r_pop_lo    <= '0;
            r_pop_flags <= '0;
        end else begin
            if (w_accept) begin
                r_op        <= bus.op_code;
                r_ret_pc    <= bus.ret_pc;
                r_target_pc <= bus.target_pc;
                r_flags     <= bus.flags_in;
            end
            if (bus.mem_ack) begin
                if (r_state == POP_HI) r_pop_hi    <= bus.mem_rdata;
                if (r_state == POP_LO) r_pop_lo    <= bus.mem_rdata;
                if (r_state == POP_F)  r_pop_flags <= bus.mem_rdata[FLAG_W-1:0];
            end
        end
    end

    // Push writes at SP then decrements; pop reads at SP+1 and increments on the ack edge.
    always_comb begin
        w_next_state = r_state;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_addr   = '0;
        w_mem_wdata  = '0;
        case (r_state)
            IDLE: begin
                if (bus.op_valid) begin
                    case (bus.op_code)
                        OP_CALL: w_next_state = PUSH_LO;
                        OP_INT:  w_next_state = PUSH_F;
                        default: w_next_state = POP_HI;
                    endcase
                end
            end
            PUSH_F: begin
                w_mem_req   = 1'b1;
                w_mem_we    = 1'b1;
                w_mem_addr  = w_sp;
                w_mem_wdata = {{(DW-FLAG_W){1'b0}}, r_flags};
                if (bus.mem_ack) w_next_state = PUSH_LO;
            end
            PUSH_LO: begin
                w_mem_req   = 1'b1;
                w_mem_we    = 1'b1;
                w_mem_addr  = w_sp;
                w_mem_wdata = r_ret_pc[DW-1:0];
                if (bus.mem_ack) w_next_state = PUSH_HI;
            end
            PUSH_HI: begin
                w_mem_req   = 1'b1;
                w_mem_we    = 1'b1;
                w_mem_addr  = w_sp;
                w_mem_wdata = r_ret_pc[2*DW-1:DW];
                if (bus.mem_ack) w_next_state = DONE;
            end
            POP_HI: begin
                w_mem_req  = 1'b1;
                w_mem_addr = w_sp_plus1;
                if (bus.mem_ack) w_next_state = POP_LO;
            end
            POP_LO: begin
                w_mem_req  = 1'b1;
                w_mem_addr = w_sp_plus1;
                if (bus.mem_ack) w_next_state = (r_op == OP_RTI) ? POP_F : DONE;
            end
            POP_F: begin
                w_mem_req  = 1'b1;
                w_mem_addr = w_sp_plus1;
                if (bus.mem_ack) w_next_state = DONE;
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign w_sp_dec    = w_mem_req &&  w_mem_we && bus.mem_ack;
    assign w_sp_inc    = w_mem_req && !w_mem_we && bus.mem_ack;
    assign w_done      = (r_state == DONE);
    assign w_is_pop_op = (r_op == OP_RET) || (r_op == OP_RTI);

    assign bus.op_ready   = (r_state == IDLE);
    assign bus.stall      = (r_state != IDLE) || w_accept;
    assign bus.mem_req    = w_mem_req;
    assign bus.mem_we     = w_mem_we;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_wdata  = w_mem_wdata;
    assign bus.pc_load    = w_done;
    assign bus.pc_next    = !w_done     ? '0 :
                            w_is_pop_op ? {r_pop_hi, r_pop_lo} : r_target_pc;
    assign bus.flags_load = w_done && (r_op == OP_RTI);
    assign bus.flags_out  = bus.flags_load ? r_pop_flags : '0;
    assign bus.sp_out     = w_sp;

endmodule
`default_nettype wire

// File: tb/tb_stack_op_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_stack_op_sequencer                                            |
// | Directed stimulus with memory-access and PC-load scoreboards.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_stack_op_sequencer;
    import stack_seq_pkg::*;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [15:0] data;
    } acc_t;

    typedef struct {
        logic [31:0] pc;
        logic        fl;
        logic [3:0]  flags;
    } pcx_t;

    logic clk = 1'b0;
    logic reset;

    int checks   = 0;
    int failures = 0;
    int ack_wait = 0;

    acc_t        exp_q[$];
    pcx_t        exp_pc_q[$];
    logic [15:0] mem [logic [31:0]];
    logic [31:0] exp_sp;

    stack_op_sequencer_if #(.ADDR_W(32), .DW(16), .FLAG_W(4)) bus_a();
    stack_op_sequencer_if #(.ADDR_W(32), .DW(16), .FLAG_W(4)) bus_b();

    stack_op_sequencer u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    stack_op_sequencer #(.SP_INIT(32'h0000_0000)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 16'h0000;
    endfunction

    // Memory responder for bus_a: inserts ack_wait idle cycles, checks each access on ack.
    initial begin : p_mem
        int          cnt;
        logic [31:0] s_addr;
        logic [15:0] s_wdata;
        logic [31:0] s_sp;
        acc_t        e;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bus_a.mem_req === 1'b1) begin
                if (cnt == 0) begin
                    s_addr  = bus_a.mem_addr;
                    s_wdata = bus_a.mem_wdata;
                    s_sp    = bus_a.sp_out;
                end else begin
                    chk("hold_addr",  bus_a.mem_addr,  s_addr);
                    chk("hold_wdata", bus_a.mem_wdata, s_wdata);
                    chk("hold_sp",    bus_a.sp_out,    s_sp);
                end
                if (cnt == ack_wait) begin
                    bus_a.mem_ack = 1'b1;
                    chk("acc_pending", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("acc_we",   bus_a.mem_we,   e.we);
                        chk("acc_addr", bus_a.mem_addr, e.addr);
                        if (e.we) chk("acc_wdata", bus_a.mem_wdata, e.data);
                    end
                    if (bus_a.mem_we) mem[bus_a.mem_addr] = bus_a.mem_wdata;
                    else              bus_a.mem_rdata = mem_rd(bus_a.mem_addr);
                    cnt = 0;
                end else begin
                    bus_a.mem_ack = 1'b0;
                    cnt++;
                end
            end else begin
                bus_a.mem_ack = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin : p_pc_mon
        pcx_t p;
        forever begin
            @(negedge clk);
            if (bus_a.pc_load === 1'b1) begin
                chk("pc_pending", exp_pc_q.size() > 0, 1'b1);
                if (exp_pc_q.size() > 0) begin
                    p = exp_pc_q.pop_front();
                    chk("pc_next",    bus_a.pc_next,    p.pc);
                    chk("flags_load", bus_a.flags_load, p.fl);
                    chk("flags_out",  bus_a.flags_out,  p.flags);
                end
            end
        end
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic expect_op(input op_code_t code, input logic [31:0] ret, input logic [31:0] tgt,
                             input logic [3:0] fl, input logic [31:0] exp_pc);
        case (code)
            OP_CALL: begin
                exp_q.push_back('{1'b1, exp_sp,          ret[15:0]});
                exp_q.push_back('{1'b1, exp_sp - 32'd1,  ret[31:16]});
                exp_sp = exp_sp - 32'd2;
                exp_pc_q.push_back('{tgt, 1'b0, 4'h0});
            end
            OP_INT: begin
                exp_q.push_back('{1'b1, exp_sp,          {12'h000, fl}});
                exp_q.push_back('{1'b1, exp_sp - 32'd1,  ret[15:0]});
                exp_q.push_back('{1'b1, exp_sp - 32'd2,  ret[31:16]});
                exp_sp = exp_sp - 32'd3;
                exp_pc_q.push_back('{tgt, 1'b0, 4'h0});
            end
            OP_RET: begin
                exp_q.push_back('{1'b0, exp_sp + 32'd1, 16'h0});
                exp_q.push_back('{1'b0, exp_sp + 32'd2, 16'h0});
                exp_sp = exp_sp + 32'd2;
                exp_pc_q.push_back('{exp_pc, 1'b0, 4'h0});
            end
            default: begin
                exp_q.push_back('{1'b0, exp_sp + 32'd1, 16'h0});
                exp_q.push_back('{1'b0, exp_sp + 32'd2, 16'h0});
                exp_q.push_back('{1'b0, exp_sp + 32'd3, 16'h0});
                exp_sp = exp_sp + 32'd3;
                exp_pc_q.push_back('{exp_pc, 1'b1, fl});
            end
        endcase
    endtask

    task automatic do_op(input string name, input op_code_t code, input logic [31:0] ret,
                         input logic [31:0] tgt, input logic [3:0] fl, input logic [31:0] exp_pc,
                         input bit hold, input int exp_stall);
        int n;
        expect_op(code, ret, tgt, fl, exp_pc);
        @(negedge clk);
        bus_a.op_valid  = 1'b1;
        bus_a.op_code   = code;
        bus_a.ret_pc    = (code == OP_CALL || code == OP_INT) ? ret : $urandom;
        bus_a.target_pc = (code == OP_CALL || code == OP_INT) ? tgt : $urandom;
        bus_a.flags_in  = (code == OP_INT) ? fl : 4'($urandom);
        #1;
        chk({name, "_accept_stall"}, bus_a.stall, 1'b1);
        chk({name, "_accept_ready"}, bus_a.op_ready, 1'b1);
        @(posedge clk);
        #1;
        if (!hold) bus_a.op_valid = 1'b0;
        n = 1;
        while (n < 200) begin
            @(negedge clk);
            if (bus_a.op_ready) bus_a.op_valid = 1'b0;
            #1;
            if (!bus_a.stall) break;
            chk({name, "_busy_ready"}, bus_a.op_ready, 1'b0);
            n++;
        end
        chk({name, "_stall_cycles"}, n, exp_stall);
        chk({name, "_sp"}, bus_a.sp_out, exp_sp);
        chk({name, "_acc_left"}, exp_q.size(), 0);
        chk({name, "_pc_left"}, exp_pc_q.size(), 0);
    endtask

    initial begin : p_main
        int n;
        reset           = 1'b0;
        bus_a.op_valid  = 1'b0;
        bus_a.op_code   = OP_CALL;
        bus_a.ret_pc    = '0;
        bus_a.target_pc = '0;
        bus_a.flags_in  = '0;
        bus_a.mem_ack   = 1'b0;
        bus_a.mem_rdata = '0;
        bus_b.op_valid  = 1'b0;
        bus_b.op_code   = OP_CALL;
        bus_b.ret_pc    = '0;
        bus_b.target_pc = '0;
        bus_b.flags_in  = '0;
        bus_b.mem_ack   = 1'b1;
        bus_b.mem_rdata = '0;
        exp_sp          = 32'h0000_0FFE;

        repeat (3) @(negedge clk);
        chk("rst_ready",   bus_a.op_ready,   1'b1);
        chk("rst_stall",   bus_a.stall,      1'b0);
        chk("rst_mem_req", bus_a.mem_req,    1'b0);
        chk("rst_addr",    bus_a.mem_addr,   32'h0);
        chk("rst_pc_load", bus_a.pc_load,    1'b0);
        chk("rst_pc_next", bus_a.pc_next,    32'h0);
        chk("rst_fl_load", bus_a.flags_load, 1'b0);
        chk("rst_sp",      bus_a.sp_out,     32'h0000_0FFE);
        reset = 1'b1;

        do_op("call",  OP_CALL, 32'h0001_2345, 32'h0000_0100, 4'h0, 32'h0, 1'b0, 4);
        do_op("ret",   OP_RET,  32'h0,         32'h0,         4'h0, 32'h0001_2345, 1'b0, 4);
        do_op("int",   OP_INT,  32'h0000_00AA, 32'h0000_0200, 4'b1010, 32'h0, 1'b0, 5);
        do_op("rti",   OP_RTI,  32'h0,         32'h0,         4'b1010, 32'h0000_00AA, 1'b0, 5);
        chk("mem_flag_word", mem_rd(32'h0000_0FFE), 16'h000A);

        ack_wait = 3;
        do_op("call_wait", OP_CALL, 32'h0003_0004, 32'h0000_0300, 4'h0, 32'h0, 1'b0, 10);
        ack_wait = 0;

        do_op("call_hold", OP_CALL, 32'h0005_0006, 32'h0000_0400, 4'h0, 32'h0, 1'b1, 4);
        repeat (3) begin
            @(negedge clk);
            chk("hold_idle_req",   bus_a.mem_req,  1'b0);
            chk("hold_idle_ready", bus_a.op_ready, 1'b1);
        end

        // Abort a CALL while it waits in PUSH_HI.
        ack_wait = 3;
        expect_op(OP_CALL, 32'h0007_0008, 32'h0000_0500, 4'h0, 32'h0);
        @(negedge clk);
        bus_a.op_valid  = 1'b1;
        bus_a.op_code   = OP_CALL;
        bus_a.ret_pc    = 32'h0007_0008;
        bus_a.target_pc = 32'h0000_0500;
        @(posedge clk);
        #1;
        bus_a.op_valid = 1'b0;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (bus_a.mem_req && bus_a.mem_addr == 32'h0000_0FF9) break;
            n++;
        end
        chk("abort_reach_push_hi", n < 100, 1'b1);
        reset = 1'b0;
        exp_q.delete();
        exp_pc_q.delete();
        #1;
        chk("abort_mem_req", bus_a.mem_req,  1'b0);
        chk("abort_stall",   bus_a.stall,    1'b0);
        chk("abort_sp",      bus_a.sp_out,   32'h0000_0FFE);
        chk("abort_ready",   bus_a.op_ready, 1'b1);
        repeat (2) @(negedge clk);
        reset    = 1'b1;
        ack_wait = 0;
        exp_sp   = 32'h0000_0FFE;
        do_op("call_after_abort", OP_CALL, 32'h0011_0022, 32'h0000_0600, 4'h0, 32'h0, 1'b0, 4);

        // Wrap-around on the SP_INIT=0 instance; its ack is tied high.
        @(negedge clk);
        bus_b.op_valid  = 1'b1;
        bus_b.op_code   = OP_CALL;
        bus_b.ret_pc    = 32'h0009_000A;
        bus_b.target_pc = 32'h0000_0700;
        @(posedge clk);
        #1;
        bus_b.op_valid = 1'b0;
        @(negedge clk);
        chk("wrap_req0",   bus_b.mem_req,   1'b1);
        chk("wrap_addr0",  bus_b.mem_addr,  32'h0000_0000);
        chk("wrap_data0",  bus_b.mem_wdata, 16'h000A);
        @(negedge clk);
        chk("wrap_addr1",  bus_b.mem_addr,  32'hFFFF_FFFF);
        chk("wrap_data1",  bus_b.mem_wdata, 16'h0009);
        chk("wrap_sp1",    bus_b.sp_out,    32'hFFFF_FFFF);
        @(negedge clk);
        chk("wrap_pc_load", bus_b.pc_load,  1'b1);
        chk("wrap_pc_next", bus_b.pc_next,  32'h0000_0700);
        chk("wrap_sp2",     bus_b.sp_out,   32'hFFFF_FFFE);
        @(negedge clk);
        chk("wrap_ready",   bus_b.op_ready, 1'b1);

        chk("end_acc_left", exp_q.size(), 0);
        chk("end_pc_left",  exp_pc_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
